// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and constants for the pipeline control block.
// REG_ADDR_WIDTH is taken from the shared defines when they are already loaded.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package pipe_ctrl_pkg;

  localparam int unsigned REG_AW = `REG_ADDR_WIDTH;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMcBusy = 2'd1,
    StFlush  = 2'd2
  } state_e;

  // Bit positions inside the stall vector, LSB first.
  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  localparam logic [5:0] STALL_LU   = 6'b000111;
  localparam logic [5:0] STALL_MC   = 6'b001111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Combinational load-use hazard compare between the EX load and the ID reads.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic              i_rd_en1,
  input  logic              i_rd_en2,
  input  logic [REG_AW-1:0] i_rd_addr1,
  input  logic [REG_AW-1:0] i_rd_addr2,
  input  logic              i_ex_load,
  input  logic              i_ex_wen,
  input  logic [REG_AW-1:0] i_ex_waddr,
  output logic              o_load_use
);

  logic w_src1_hit;
  logic w_src2_hit;
  logic w_ex_writes;

  always_comb begin
    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    w_ex_writes = i_ex_load & i_ex_wen & (i_ex_waddr != '0);
    w_src1_hit  = i_rd_en1 & (i_rd_addr1 == i_ex_waddr);
    w_src2_hit  = i_rd_en2 & (i_rd_addr2 == i_ex_waddr);
    o_load_use  = w_ex_writes & (w_src1_hit | w_src2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: load-use stalls, multi-cycle op sequencing, flush and
// a saturating stall-cycle performance counter.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_CNT_W = 6,
  parameter int unsigned STALL_W  = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_rd_en1_in,
  input  logic                       id_rd_en2_in,
  input  logic [`REG_ADDR_WIDTH-1:0] id_rd_addr1_in,
  input  logic [`REG_ADDR_WIDTH-1:0] id_rd_addr2_in,
  input  logic                       ex_wen_in,
  input  logic                       ex_load_in,
  input  logic [`REG_ADDR_WIDTH-1:0] ex_waddr_in,
  input  logic                       ex_mc_start_in,
  input  logic [MC_CNT_W-1:0]        ex_mc_len_in,
  input  logic                       flush_req_in,
  output logic [STALL_W-1:0]         stall_out,
  output logic                       flush_out,
  output logic                       mc_busy_out,
  output logic                       mc_done_out,
  output logic [31:0]                stall_cnt_out
);

  state_e                r_state;
  state_e                w_state_d;
  logic [MC_CNT_W-1:0]   r_mc_cnt;
  logic [MC_CNT_W-1:0]   w_mc_cnt_d;
  logic [31:0]           r_stall_cnt;
  logic                  w_load_use;
  logic [STALL_WB:STALL_PC] w_stall;
  logic                  w_flush;
  logic                  w_busy;
  logic                  w_done;

  hazard_det u_hazard_det (
    .i_rd_en1   (id_rd_en1_in),
    .i_rd_en2   (id_rd_en2_in),
    .i_rd_addr1 (id_rd_addr1_in),
    .i_rd_addr2 (id_rd_addr2_in),
    .i_ex_load  (ex_load_in),
    .i_ex_wen   (ex_wen_in),
    .i_ex_waddr (ex_waddr_in),
    .o_load_use (w_load_use)
  );

  always_comb begin
    w_state_d  = r_state;
    w_mc_cnt_d = r_mc_cnt;
    w_stall    = STALL_NONE;
    w_flush    = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_load_use) begin
          w_stall = STALL_LU;
        end
        if (ex_mc_start_in) begin
          if (ex_mc_len_in > MC_CNT_W'(1)) begin
            w_mc_cnt_d = ex_mc_len_in - MC_CNT_W'(1);
            w_state_d  = StMcBusy;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      StMcBusy: begin
        w_busy = 1'b1;
        if (r_mc_cnt <= MC_CNT_W'(1)) begin
          // Final cycle: release the pipeline while reporting completion.
          w_done     = 1'b1;
          w_mc_cnt_d = '0;
          w_state_d  = StIdle;
        end else begin
          w_stall    = STALL_MC;
          w_mc_cnt_d = r_mc_cnt - MC_CNT_W'(1);
        end
      end
      StFlush: begin
        w_flush   = 1'b1;
        w_state_d = StIdle;
      end
      default: begin
        w_state_d  = StIdle;
        w_mc_cnt_d = '0;
      end
    endcase

    // Flush wins everywhere; outputs still reflect the current state except done.
    if (flush_req_in) begin
      w_state_d  = StFlush;
      w_mc_cnt_d = '0;
      w_done     = 1'b0;
    end

    // Hold every output low while reset is asserted, independent of the clock.
    if (!rst_n) begin
      w_stall = STALL_NONE;
      w_flush = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_mc_cnt <= '0;
    end else begin
      r_state  <= w_state_d;
      r_mc_cnt <= w_mc_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if ((w_stall != STALL_NONE) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_out     = STALL_W'(w_stall);
  assign flush_out     = w_flush;
  assign mc_busy_out   = w_busy;
  assign mc_done_out   = w_done;
  assign stall_cnt_out = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module tb_pipe_ctrl;

  localparam int unsigned AW = `REG_ADDR_WIDTH;

  logic          clk;
  logic          rst_n;
  logic          id_rd_en1_in;
  logic          id_rd_en2_in;
  logic [AW-1:0] id_rd_addr1_in;
  logic [AW-1:0] id_rd_addr2_in;
  logic          ex_wen_in;
  logic          ex_load_in;
  logic [AW-1:0] ex_waddr_in;
  logic          ex_mc_start_in;
  logic [5:0]    ex_mc_len_in;
  logic          flush_req_in;
  logic [5:0]    stall_out;
  logic          flush_out;
  logic          mc_busy_out;
  logic          mc_done_out;
  logic [31:0]   stall_cnt_out;

  int n_pass  = 0;
  int n_total = 0;

  pipe_ctrl #(
    .MC_CNT_W (6),
    .STALL_W  (6)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rd_en1_in   (id_rd_en1_in),
    .id_rd_en2_in   (id_rd_en2_in),
    .id_rd_addr1_in (id_rd_addr1_in),
    .id_rd_addr2_in (id_rd_addr2_in),
    .ex_wen_in      (ex_wen_in),
    .ex_load_in     (ex_load_in),
    .ex_waddr_in    (ex_waddr_in),
    .ex_mc_start_in (ex_mc_start_in),
    .ex_mc_len_in   (ex_mc_len_in),
    .flush_req_in   (flush_req_in),
    .stall_out      (stall_out),
    .flush_out      (flush_out),
    .mc_busy_out    (mc_busy_out),
    .mc_done_out    (mc_done_out),
    .stall_cnt_out  (stall_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [5:0] st, input logic fl,
                          input logic bz, input logic dn);
    chk({tag, ".stall"}, 32'(stall_out), 32'(st));
    chk({tag, ".flush"}, 32'(flush_out), 32'(fl));
    chk({tag, ".busy"}, 32'(mc_busy_out), 32'(bz));
    chk({tag, ".done"}, 32'(mc_done_out), 32'(dn));
  endtask

  task automatic set_lu(input logic on);
    ex_load_in     = on;
    ex_wen_in      = on;
    ex_waddr_in    = on ? AW'(3) : '0;
    id_rd_en2_in   = on;
    id_rd_addr2_in = on ? AW'(3) : '0;
  endtask

  initial begin
    int done_seen;
    rst_n          = 1'b0;
    id_rd_en1_in   = 1'b0;
    id_rd_en2_in   = 1'b0;
    id_rd_addr1_in = '0;
    id_rd_addr2_in = '0;
    ex_wen_in      = 1'b0;
    ex_load_in     = 1'b0;
    ex_waddr_in    = '0;
    ex_mc_start_in = 1'b0;
    ex_mc_len_in   = '0;
    flush_req_in   = 1'b0;

    // Reset: outputs low even with a hazard and a short op presented.
    #3;
    set_lu(1'b1);
    ex_mc_start_in = 1'b1;
    #1;
    chk_outs("rst", 6'b000000, 1'b0, 1'b0, 1'b0);
    chk("rst.cnt", stall_cnt_out, 32'd0);
    set_lu(1'b0);
    ex_mc_start_in = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk_outs("idle", 6'b000000, 1'b0, 1'b0, 1'b0);

    // Load-use via source 2, then ex_waddr = 0, then source 1, then non-load.
    set_lu(1'b1);
    #1;
    chk_outs("lu2", 6'b000111, 1'b0, 1'b0, 1'b0);
    tick();
    chk("lu2.cnt", stall_cnt_out, 32'd1);
    chk("lu2.stay", 32'(mc_busy_out), 32'd0);
    ex_waddr_in = '0;
    id_rd_addr2_in = '0;
    #1;
    chk("lu.x0", 32'(stall_out), 32'd0);
    id_rd_en2_in   = 1'b0;
    id_rd_en1_in   = 1'b1;
    id_rd_addr1_in = AW'(7);
    ex_waddr_in    = AW'(7);
    #1;
    chk("lu1", 32'(stall_out), 32'h07);
    id_rd_en1_in = 1'b0;
    #1;
    chk("lu1.noen", 32'(stall_out), 32'd0);
    id_rd_en1_in = 1'b1;
    ex_load_in   = 1'b0;
    #1;
    chk("lu1.noload", 32'(stall_out), 32'd0);
    id_rd_en1_in   = 1'b0;
    id_rd_addr1_in = '0;
    set_lu(1'b0);
    tick();

    // Multi-cycle len=4, hazard and a late start presented while busy.
    ex_mc_start_in = 1'b1;
    ex_mc_len_in   = 6'd4;
    #1;
    chk_outs("mc4.s", 6'b000000, 1'b0, 1'b0, 1'b0);
    tick();
    ex_mc_start_in = 1'b0;
    set_lu(1'b1);
    #1;
    chk_outs("mc4.1", 6'b001111, 1'b0, 1'b1, 1'b0);
    tick();
    ex_mc_start_in = 1'b1;
    ex_mc_len_in   = 6'd6;
    #1;
    chk_outs("mc4.2", 6'b001111, 1'b0, 1'b1, 1'b0);
    tick();
    ex_mc_start_in = 1'b0;
    #1;
    chk_outs("mc4.3", 6'b000000, 1'b0, 1'b1, 1'b1);
    set_lu(1'b0);
    tick();
    chk_outs("mc4.4", 6'b000000, 1'b0, 1'b0, 1'b0);
    chk("mc4.cnt", stall_cnt_out, 32'd3);

    // Lengths 1 and 0 finish in the start cycle.
    for (int l = 1; l >= 0; l--) begin
      ex_mc_start_in = 1'b1;
      ex_mc_len_in   = 6'(l);
      #1;
      chk_outs($sformatf("len%0d.s", l), 6'b000000, 1'b0, 1'b0, 1'b1);
      tick();
      ex_mc_start_in = 1'b0;
      #1;
      chk_outs($sformatf("len%0d.n", l), 6'b000000, 1'b0, 1'b0, 1'b0);
    end

    // Length 63: done exactly 62 cycles after start.
    ex_mc_start_in = 1'b1;
    ex_mc_len_in   = 6'd63;
    #1;
    tick();
    ex_mc_start_in = 1'b0;
    for (int i = 1; i <= 62; i++) begin
      #1;
      chk($sformatf("len63.done%0d", i), 32'(mc_done_out), (i == 62) ? 32'd1 : 32'd0);
      chk($sformatf("len63.busy%0d", i), 32'(mc_busy_out), 32'd1);
      tick();
    end
    chk("len63.end", 32'(mc_busy_out), 32'd0);
    chk("len63.cnt", stall_cnt_out, 32'd64);

    // Flush at cycle 3 of a len=10 op.
    ex_mc_start_in = 1'b1;
    ex_mc_len_in   = 6'd10;
    #1;
    tick();
    ex_mc_start_in = 1'b0;
    tick();
    tick();
    flush_req_in = 1'b1;
    #1;
    chk_outs("fl.req", 6'b001111, 1'b0, 1'b1, 1'b0);
    tick();
    flush_req_in = 1'b0;
    #1;
    chk_outs("fl.f", 6'b000000, 1'b1, 1'b0, 1'b0);
    tick();
    chk_outs("fl.idle", 6'b000000, 1'b0, 1'b0, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (mc_done_out) done_seen++;
      tick();
    end
    chk("fl.nodone", 32'(done_seen), 32'd0);
    chk("fl.cnt", stall_cnt_out, 32'd67);

    // Flush with a len=1 start suppresses done; held flush repeats FLUSH.
    ex_mc_start_in = 1'b1;
    ex_mc_len_in   = 6'd1;
    flush_req_in   = 1'b1;
    #1;
    chk("fl1.done", 32'(mc_done_out), 32'd0);
    tick();
    ex_mc_start_in = 1'b0;
    #1;
    chk("fl1.f1", 32'(flush_out), 32'd1);
    tick();
    flush_req_in = 1'b0;
    #1;
    chk("fl1.f2", 32'(flush_out), 32'd1);
    tick();
    chk_outs("fl1.idle", 6'b000000, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in MC_BUSY, then a fresh len=2 op.
    ex_mc_start_in = 1'b1;
    ex_mc_len_in   = 6'd10;
    #1;
    tick();
    ex_mc_start_in = 1'b0;
    tick();
    chk("rmid.busy", 32'(mc_busy_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_outs("rmid", 6'b000000, 1'b0, 1'b0, 1'b0);
    chk("rmid.cnt", stall_cnt_out, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk_outs("rrel", 6'b000000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_outs("rrel2", 6'b000000, 1'b0, 1'b0, 1'b0);
    ex_mc_start_in = 1'b1;
    ex_mc_len_in   = 6'd2;
    #1;
    chk("len2.s", 32'(mc_done_out), 32'd0);
    tick();
    ex_mc_start_in = 1'b0;
    #1;
    chk_outs("len2.1", 6'b000000, 1'b0, 1'b1, 1'b1);
    tick();
    chk_outs("len2.2", 6'b000000, 1'b0, 1'b0, 1'b0);

    // Saturation of the stall counter.
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    #1;
    chk("sat.pre", stall_cnt_out, 32'hFFFF_FFFE);
    set_lu(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat%0d", i), stall_cnt_out, 32'hFFFF_FFFF);
    end
    set_lu(1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The module SHALL have parameter MC_CNT_W, default 6, the width of the multi-cycle length field.
REQ-002 The module SHALL have parameter STALL_W, default 6, the stall vector width, bit order {wb,mem,ex,id,if,pc} from MSB to LSB.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 id_rd_en1_in / id_rd_en2_in  in  1 each  decode-stage register read enables.
REQ-006 id_rd_addr1_in / id_rd_addr2_in  in  `REG_ADDR_WIDTH each  decode-stage read addresses.
REQ-007 ex_wen_in, ex_load_in  in  1 each  EX instruction writes a register; EX instruction is a load.
REQ-008 ex_waddr_in  in  `REG_ADDR_WIDTH  EX destination register.
REQ-009 ex_mc_start_in  in  1  EX issues a multi-cycle operation this cycle.
REQ-010 ex_mc_len_in  in  MC_CNT_W  total cycles of the multi-cycle op.
REQ-011 flush_req_in  in  1  branch/exception flush request.
REQ-012 stall_out  out  STALL_W  per-stage hold; flush_out  out  1  clear IF/ID/EX registers.
REQ-013 mc_busy_out, mc_done_out  out  1 each  multi-cycle op in progress; single-cycle completion pulse.
REQ-014 stall_cnt_out  out  32  saturating count of cycles with any stall bit set.

Function
REQ-015 The FSM SHALL have states IDLE, MC_BUSY and FLUSH, with state encodings defined in the shared package.
REQ-016 A load-use hazard SHALL be ex_load_in & ex_wen_in & (ex_waddr_in != 0) & ((id_rd_en1_in & addr1 == ex_waddr_in) | (id_rd_en2_in & addr2 == ex_waddr_in)).
REQ-017 Load-use detection SHALL be combinational, the same cycle, and SHALL drive stall_out = 6'b000111 in IDLE; it SHALL NOT change state.
REQ-018 In IDLE, ex_mc_start_in with ex_mc_len_in = N >= 2 SHALL load counter = N-1 and move to MC_BUSY at the next edge.
REQ-019 A len of 0 or 1 SHALL complete immediately: mc_done_out = 1 in the start cycle, and the state SHALL remain IDLE.
REQ-020 In MC_BUSY the counter SHALL decrement each cycle.
REQ-021 In MC_BUSY, stall_out SHALL be 6'b001111, mc_busy_out SHALL be 1 and load-use SHALL be ignored.
REQ-022 In MC_BUSY, when counter == 1, mc_done_out SHALL be 1 that cycle, and the state SHALL return to IDLE at the next edge.
REQ-023 In MC_BUSY, stall_out SHALL be 0 in that final (done) cycle.
REQ-024 ex_mc_start_in SHALL be ignored while in MC_BUSY.
REQ-025 flush_req_in SHALL have the highest priority in every state: the counter is cleared and the next state is FLUSH.
REQ-026 In FLUSH, flush_out = 1 and stall_out = 0 for exactly one cycle, then IDLE, or FLUSH again if flush_req_in is still high.
REQ-027 In the cycle flush_req_in is sampled, outputs SHALL follow the current state, except that mc_done_out SHALL be suppressed.
REQ-028 stall_cnt_out SHALL increment by 1 on each edge where stall_out != 0, and saturate at 32'hFFFF_FFFF.
REQ-029 mc_busy_out SHALL be 1 only in MC_BUSY; mc_done_out SHALL never be high for two consecutive cycles from one op.

Reset
REQ-030 While rst_n = 0: state = IDLE, counter = 0, stall_cnt_out = 0, with no dependence on clk.
REQ-031 While rst_n = 0: stall_out = 0, flush_out = 0, mc_busy_out = 0 and mc_done_out = 0.
REQ-032 Reset asserted mid-MC_BUSY or mid-FLUSH SHALL abort the operation; after deassertion the block SHALL resume in IDLE with no done pulse.

Structure
REQ-033 The shared defines/package SHALL hold the FSM state encodings, the STALL_W bit-index constants (STALL_PC..STALL_WB) and the stall pattern constants STALL_LU = 6'b000111 and STALL_MC = 6'b001111.
REQ-034 `REG_ADDR_WIDTH SHALL be reused from the existing shared defines.
REQ-035 One sub-module, hazard_det, SHALL contain the combinational load-use compare (REQ-016); the FSM, counter and perf counter SHALL stay in pipe_ctrl.

Verification
REQ-036 Load-use: ex_load_in = 1, ex_waddr_in = 5'd3, id_rd_en2_in = 1, addr2 = 3 -> stall_out = 6'b000111 that cycle; with ex_waddr_in = 0 -> stall_out = 0.
REQ-037 Multi-cycle: start with len = 4 -> mc_busy_out high 3 cycles, stall_out = 6'b001111 for 2, mc_done_out on the 3rd post-start cycle, stall_cnt_out += 2.
REQ-038 Length edge: len = 1 and len = 0 -> mc_done_out in the start cycle, never MC_BUSY; len = 63 -> done exactly 62 cycles after start.
REQ-039 Flush mid-op: len = 10, flush_req_in at cycle 3 -> next cycle flush_out = 1 and stall_out = 0, then IDLE, no mc_done_out ever.
REQ-040 Reset mid-op: rst_n low during MC_BUSY without a clk edge -> outputs 0 immediately; after release, a new len = 2 op completes normally.
REQ-041 Saturation: force stall_cnt_out to 32'hFFFF_FFFE, apply 3 stall cycles -> holds at 32'hFFFF_FFFF.
